// File: rtl/cache_types_pkg.sv
// Shared cache types: line/beat geometry, adaptor FSM states and beat index.
// Used by the cacheline adaptor and the cache datapath.
package cache_types_pkg;
    localparam int LINE_W_DEF  = 256;
    localparam int BURST_W_DEF = 64;
    localparam int BEATS_DEF   = LINE_W_DEF / BURST_W_DEF;
    localparam int ADDR_W      = 32;
    localparam int OFFSET_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } adaptor_state_e;

    typedef logic [$clog2(BEATS_DEF)-1:0] beat_idx_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction
endpackage

// File: rtl/cacheline_adaptor.sv
// Bridges a full cache line to a 4-beat memory burst, for both fills (read)
// and write-backs (write). Single FSM; counter and line registers inline.
module cacheline_adaptor
    import cache_types_pkg::*;
#(
    parameter int LINE_W  = LINE_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);
    adaptor_state_e            state_q;
    beat_idx_t                 cnt_q;
    logic [LINE_W-1:0]         wline_q;
    logic [LINE_W-1:0]         rline_q;
    logic [ADDR_W-1:0]         addr_q;

    // Fill and write-back lines are kept apart so a write-back never
    // disturbs the last fill line still being presented on line_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wline_q <= '0;
            rline_q <= '0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (write_i) begin
                        wline_q <= line_i;
                        addr_q  <= address_i;
                        cnt_q   <= '0;
                        state_q <= ST_WRITE;
                    end else if (read_i) begin
                        addr_q  <= address_i;
                        cnt_q   <= '0;
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (resp_i) begin
                        rline_q[cnt_q*BURST_W +: BURST_W] <= burst_i;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == beat_idx_t'(BEATS_DEF-1)) state_q <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    if (resp_i) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == beat_idx_t'(BEATS_DEF-1)) state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs are decodes of registered state, forced low while rst is held.
    assign read_o    = (state_q == ST_READ)  && !rst;
    assign write_o   = (state_q == ST_WRITE) && !rst;
    assign resp_o    = (state_q == ST_DONE)  && !rst;
    assign address_o = rst ? '0 : line_align(addr_q);
    assign line_o    = rst ? '0 : rline_q;
    assign burst_o   = write_o ? wline_q[cnt_q*BURST_W +: BURST_W] : '0;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: read, write, stalls, priority, reset.
module tb_cacheline_adaptor;
    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i, line_o;
    logic [31:0]  address_i, address_o;
    logic         read_i, write_i, resp_o, read_o, write_o, resp_i;
    logic [63:0]  burst_i, burst_o;

    int total = 0;
    int bad   = 0;

    cacheline_adaptor dut (
        .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i),
        .resp_o(resp_o), .burst_i(burst_i), .burst_o(burst_o),
        .address_o(address_o), .read_o(read_o), .write_o(write_o),
        .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
    localparam logic [255:0] RLINE = {B4, B3, B2, B1};
    localparam logic [255:0] WLINE = {64'hDEAD_0003_BEEF_0003, 64'hDEAD_0002_BEEF_0002,
                                      64'hDEAD_0001_BEEF_0001, 64'hDEAD_0000_BEEF_0000};

    logic [63:0]  rbeats [4];
    logic [63:0]  wbeats [4];
    logic [255:0] line2;
    int           rcnt;

    initial begin
        rbeats[0] = B1; rbeats[1] = B2; rbeats[2] = B3; rbeats[3] = B4;
        wbeats[0] = WLINE[63:0];    wbeats[1] = WLINE[127:64];
        wbeats[2] = WLINE[191:128]; wbeats[3] = WLINE[255:192];
        line2 = {64'hA4, 64'hA3, 64'hA2, 64'hA1};

        rst = 1'b1; line_i = '0; address_i = '0; read_i = 0; write_i = 0;
        resp_i = 0; burst_i = '0;
        @(negedge clk); step();
        chk("rst_read_o", 256'(read_o), 0);
        chk("rst_write_o", 256'(write_o), 0);
        chk("rst_resp_o", 256'(resp_o), 0);
        chk("rst_line_o", line_o, 0);
        chk("rst_addr_o", 256'(address_o), 0);
        chk("rst_burst_o", 256'(burst_o), 0);
        rst = 1'b0;
        step();

        // Read, no gaps
        read_i = 1; address_i = 32'h0000_1234;
        step();
        read_i = 0;
        chk("rd_read_o", 256'(read_o), 1);
        chk("rd_addr_o", 256'(address_o), 256'h1220);
        chk("rd_burst_zero", 256'(burst_o), 0);
        for (int k = 0; k < 4; k++) begin
            chk("rd_resp_low", 256'(resp_o), 0);
            resp_i = 1; burst_i = rbeats[k];
            step();
        end
        resp_i = 0;
        chk("rd_resp_o", 256'(resp_o), 1);
        chk("rd_read_o_done", 256'(read_o), 0);
        chk("rd_line_o", line_o, RLINE);
        step();
        chk("rd_resp_one_cycle", 256'(resp_o), 0);
        chk("rd_line_held", line_o, RLINE);

        // Write
        write_i = 1; line_i = WLINE; address_i = 32'h8000_003F;
        step();
        write_i = 0;
        chk("wr_write_o", 256'(write_o), 1);
        chk("wr_read_o", 256'(read_o), 0);
        chk("wr_addr_o", 256'(address_o), 256'h8000_0020);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wr_beat%0d", k), 256'(burst_o), 256'(wbeats[k]));
            chk("wr_addr_hold", 256'(address_o), 256'h8000_0020);
            resp_i = 1;
            step();
        end
        resp_i = 0;
        chk("wr_resp_o", 256'(resp_o), 1);
        chk("wr_write_o_done", 256'(write_o), 0);
        chk("wr_burst_done", 256'(burst_o), 0);
        chk("wr_line_o_untouched", line_o, RLINE);
        step();
        chk("wr_idle_resp", 256'(resp_o), 0);

        // Stalled read: two idle cycles between beats
        read_i = 1; address_i = 32'h0000_0047;
        step();
        read_i = 0;
        rcnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                for (int g = 0; g < 2; g++) begin
                    resp_i = 0; burst_i = 64'hBAD;
                    if (read_o) rcnt++;
                    chk("st_stall_no_resp", 256'(resp_o), 0);
                    step();
                end
            end
            resp_i = 1; burst_i = rbeats[k];
            if (read_o) rcnt++;
            step();
        end
        resp_i = 0;
        chk("st_read_o_cycles", 256'(rcnt), 10);
        chk("st_resp_o", 256'(resp_o), 1);
        chk("st_line_o", line_o, RLINE);
        chk("st_addr_o", 256'(address_o), 256'h40);
        step();

        // Simultaneous read/write: write goes first
        read_i = 1; write_i = 1; line_i = WLINE; address_i = 32'h0000_2000;
        step();
        write_i = 0;
        chk("sim_write_o", 256'(write_o), 1);
        chk("sim_read_o", 256'(read_o), 0);
        for (int k = 0; k < 4; k++) begin
            resp_i = 1;
            step();
        end
        resp_i = 0;
        chk("sim_wr_resp", 256'(resp_o), 1);
        step();
        chk("sim_idle_read_o", 256'(read_o), 0);
        chk("sim_idle_write_o", 256'(write_o), 0);
        step();
        read_i = 0;
        chk("sim_read_started", 256'(read_o), 1);
        for (int k = 0; k < 4; k++) begin
            resp_i = 1; burst_i = line2[k*64 +: 64];
            step();
        end
        resp_i = 0;
        chk("sim_rd_resp", 256'(resp_o), 1);
        chk("sim_rd_line", line_o, line2);
        step();

        // Reset after beat 2 of a read
        read_i = 1; address_i = 32'h0000_3000;
        step();
        read_i = 0;
        for (int k = 0; k < 2; k++) begin
            resp_i = 1; burst_i = rbeats[k];
            step();
        end
        resp_i = 0;
        rst = 1;
        step();
        chk("rr_read_o", 256'(read_o), 0);
        chk("rr_resp_o", 256'(resp_o), 0);
        chk("rr_line_o", line_o, 0);
        rst = 0;
        step();
        chk("rr_idle_read_o", 256'(read_o), 0);
        chk("rr_no_resp", 256'(resp_o), 0);
        read_i = 1; address_i = 32'h0000_3000;
        step();
        read_i = 0;
        for (int k = 0; k < 4; k++) begin
            resp_i = 1; burst_i = rbeats[k];
            step();
        end
        resp_i = 0;
        chk("rr_fresh_resp", 256'(resp_o), 1);
        chk("rr_fresh_line", line_o, RLINE);
        step();

        // Stray resp_i in IDLE
        for (int k = 0; k < 3; k++) begin
            resp_i = 1; burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
            step();
            chk("stray_read_o", 256'(read_o), 0);
            chk("stray_resp_o", 256'(resp_o), 0);
            chk("stray_line_o", line_o, RLINE);
        end
        resp_i = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 The block SHALL have parameter LINE_W, default 256, meaning cache line width in bits.
REQ-002 The block SHALL have parameter BURST_W, default 64, meaning memory beat width in bits; BEATS = LINE_W/BURST_W = 4.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have these ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- line_i  in  LINE_W  write-back line from the cache.
- line_o  out  LINE_W  assembled fill line to the cache.
- address_i  in  32  cache-side line address.
- read_i  in  1  cache fill request.
- write_i  in  1  cache write-back request.
- resp_o  out  1  one-cycle completion to the cache.
- burst_i  in  BURST_W  read beat from memory.
- burst_o  out  BURST_W  write beat to memory.
- address_o  out  32  memory address, line-aligned.
- read_o  out  1  memory read request.
- write_o  out  1  memory write request.
- resp_i  in  1  memory beat-accepted/beat-valid strobe.

Function
REQ-005 The FSM SHALL have states IDLE, READ, WRITE, DONE.
REQ-006 In IDLE with write_i=1, the block SHALL latch line_i and address_i, clear the beat counter, and enter WRITE next cycle.
REQ-007 In IDLE with read_i=1 and write_i=0, the block SHALL latch address_i, clear the beat counter, and enter READ next cycle.
REQ-008 When read_i and write_i are both 1 in IDLE, write SHALL win; read_i is not serviced until a later IDLE cycle.
REQ-009 address_o SHALL equal the latched address with bits [4:0] forced to 0, and SHALL be held constant throughout READ/WRITE.
REQ-010 read_o SHALL be 1 exactly while in READ; write_o SHALL be 1 exactly while in WRITE; both SHALL be 0 in IDLE/DONE.
REQ-011 In READ, each cycle with resp_i=1 SHALL store burst_i into line bits [64k+63:64k] (k = counter) and increment the counter; beat 0 is the least significant.
REQ-012 In WRITE, burst_o SHALL present latched-line beat k (bits [64k+63:64k]); each resp_i=1 SHALL advance k.
REQ-013 resp_i=0 cycles inside READ/WRITE SHALL stall without losing or duplicating beats; gaps between beats are legal.
REQ-014 On the cycle resp_i=1 with counter=3, the FSM SHALL move to DONE; the 2-bit counter wraps to 0.
REQ-015 DONE SHALL assert resp_o=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-016 line_o SHALL be valid in the DONE cycle of a read and held until the next read's first beat lands.
REQ-017 A request still asserted in the IDLE cycle after DONE SHALL start a new transaction; the cache SHALL drop read_i/write_i upon resp_o.
REQ-018 resp_i in IDLE or DONE SHALL be ignored.
REQ-019 The minimum latency SHALL be 6 cycles from a request sampled in IDLE to resp_o: 1 entry cycle, 4 beat cycles, 1 DONE cycle.
REQ-020 burst_o SHALL be 0 outside WRITE.

Reset
REQ-021 rst=1 at any edge, including mid-burst, SHALL force state IDLE, counter 0, and the latched line/address to 0.
REQ-022 During reset, resp_o/read_o/write_o SHALL be 0 and line_o/address_o/burst_o SHALL be 0.
REQ-023 A transaction interrupted by reset SHALL be abandoned, with no resp_o.

Structure
REQ-024 The state enum, LINE_W/BURST_W defaults and the beat-index type SHALL live in shared package cache_types_pkg, also used by the cache datapath.
REQ-025 The block SHALL be a single module with no sub-module; the counter and line register are inline.

Verification
REQ-026 Read, no gaps: read_i, address_i=0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp_i -> address_o=0x0000_1220, line_o={44..,33..,22..,11..}, resp_o at cycle 6.
REQ-027 Write: write_i, line_i=0xDEAD..BEEF pattern, address_i=0x8000_003F -> address_o=0x8000_0020, burst_o beats in LSB-first order, resp_o one cycle after the 4th resp_i.
REQ-028 Stalled read: 2 idle cycles between each resp_i -> read_o held for 4+6 cycles, line_o identical to the no-gap result.
REQ-029 Simultaneous read_i=write_i=1 -> write burst first; read starts on the IDLE cycle after DONE.
REQ-030 Reset after beat 2 of a read -> next cycle IDLE, read_o=0, no resp_o; a fresh read then completes normally.
REQ-031 Stray resp_i pulses in IDLE -> no state change, line_o unchanged.
